gray_to_bin_stage: RTL and testbench
====================================

// Module: gray_to_bin_stage
// PURPOSE
// - Downstream consumer of the btg binary-to-Gray converter. Accepts W-bit Gray words over a
//   valid/ready handshake, decodes them to binary, and presents them on a registered
//   valid/ready output.
// - Checks that consecutive accepted codes differ in exactly one bit (the Gray step rule) and
//   flags/counts violations.
// - Used wherever Gray-coded counts (e.g. position or pointer values) are decoded and sanity-checked.
// PARAMETERS
// - W             4   data width in bits (>=2)
// - CW            8   error-counter width
// - ALLOW_REPEAT  1   1: a repeated code (distance 0) is legal; 0: a repeat is a step error
// PORTS
// - clk        in   1   single clock, all logic rising-edge
// - rst_n      in   1   asynchronous active-low reset
// - g_in       in   W   Gray code input
// - in_valid   in   1   g_in valid
// - in_ready   out  1   stage can accept; transfer when in_valid && in_ready
// - b_out      out  W   decoded binary
// - out_valid  out  1   b_out valid
// - out_ready  in   1   consumer accepts; transfer when out_valid && out_ready
// - step_err   out  1   sticky: some accepted pair violated the step rule
// - err_cnt    out  CW  count of violations, saturating at 2^CW-1
// - clr_err    in   1   synchronous clear of step_err and err_cnt
// BEHAVIOUR
// - Reset (async assert, sync-released flops): out_valid=0, b_out=0, in_ready=1, step_err=0,
//   err_cnt=0, skid empty, "have_prev"=0.
// - Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Pure XOR prefix, no arithmetic width growth.
// - Buffering is a 2-entry skid: main reg (drives b_out) plus skid reg. in_ready = !skid_valid,
//   taken from a flop (no combinational path from out_ready).
// - Latency: a word accepted in cycle N appears on b_out with out_valid=1 in cycle N+1 if main
//   is empty or draining. Full throughput is 1 word/cycle while out_ready=1.
// - Accept with main empty or draining -> word goes to main. Accept while main is held
//   (out_valid && !out_ready) -> word goes to skid, and in_ready falls next cycle.
// - When main drains and skid is valid, the skid word moves to main and in_ready rises next cycle.
// - Accepting and draining in the same cycle keeps occupancy unchanged. Order is strictly FIFO;
//   no word is dropped or duplicated.
// - Step check on every accepted word: d = popcount(g_in ^ prev_g).
//   - Error if d>1, or if d==0 and ALLOW_REPEAT==0.
//   - The first word after reset is never checked. It sets prev_g and have_prev=1.
// - On error: step_err=1 next cycle; err_cnt+1 unless saturated.
//   - clr_err has priority over old state: a clr_err cycle with a simultaneous error yields
//     step_err=1, err_cnt=1.
//   - clr_err alone yields 0/0.
//   - clr_err does not affect data path or prev_g.
// - Wrap-around is legal (W=4: 1000 -> 0000, d=1).
// - Reset mid-transfer discards main, skid, and prev_g. The next accepted word is treated as the first.
// STRUCTURE
// - Package gray_pkg:
//   - function gray2bin(W-wide)
//   - function popcount
//   - localparam DEFAULT_W=4
//   - typedef for the W-bit code word
// - One sub-module: gray_skid_buf (2-entry valid/ready skid buffer, parameter W).
// - Decode and step checker live in the top module.
// TESTING (W=4, ALLOW_REPEAT=1, CW=8)
// - Basic decode: stream Gray 0000,0001,0011,0010 with out_ready=1.
//   Expect b_out 0,1,2,3 one cycle after each accept, step_err=0.
// - Full cycle: Gray codes for 0..15, then back to 0000.
//   Expect b_out 0..15,0 in order, err_cnt=0 (wrap is legal).
// - Step error: send 0001 then 0010 (d=2). Expect step_err=1 and err_cnt=1 next cycle.
//   Then assert clr_err together with another bad step (0010 -> 0101). Expect err_cnt=1, step_err=1.
// - Backpressure: out_ready=0 for 3 cycles while in_valid=1 with 0000,0001,0011.
//   Expect in_ready=0 after 2 words are held; release out_ready -> 0,1,2 exit in order, none lost.
// - Saturation: force 300 bad steps. Expect err_cnt holds at 255, step_err=1.
// - Mid-run reset: assert rst_n=0 with both entries full.
//   Expect out_valid=0 and in_ready=1 immediately; the next word (e.g. 1111) is not flagged.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code decode stage: prefix-XOR decode and bit counting.
package gray_pkg;

  localparam int DEFAULT_W = 4;
  localparam int MAX_W     = 64;

  typedef logic [DEFAULT_W-1:0] gray_word_t;

  // Operands narrower than MAX_W are zero-extended, which leaves the low bits of the decode unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_skid_buf.sv
// Two-entry valid/ready skid buffer; the input ready is taken purely from a register.
module gray_skid_buf #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_inData,
  input  logic         i_inValid,
  output logic         o_inReady,
  output logic [W-1:0] o_outData,
  output logic         o_outValid,
  input  logic         i_outReady
);

  logic [W-1:0] r_mainData;
  logic         r_mainValid;
  logic [W-1:0] r_skidData;
  logic         r_skidValid;
  logic         w_accept;
  logic         w_mainFree;

  assign o_inReady  = !r_skidValid;
  assign o_outData  = r_mainData;
  assign o_outValid = r_mainValid;
  assign w_accept   = i_inValid && !r_skidValid;
  assign w_mainFree = !r_mainValid || i_outReady;

  // The skid only fills while main is stalled, so it always drains into main before new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainData  <= '0;
      r_mainValid <= 1'b0;
      r_skidData  <= '0;
      r_skidValid <= 1'b0;
    end else if (w_mainFree) begin
      if (r_skidValid) begin
        r_mainData  <= r_skidData;
        r_mainValid <= 1'b1;
        r_skidValid <= 1'b0;
      end else if (w_accept) begin
        r_mainData  <= i_inData;
        r_mainValid <= 1'b1;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidData  <= i_inData;
      r_skidValid <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_to_bin_stage.sv
// Decodes a Gray-coded word stream to binary through a skid buffer and checks the one-bit step rule.
module gray_to_bin_stage
  import gray_pkg::*;
#(
  parameter int W            = DEFAULT_W,
  parameter int CW           = 8,
  parameter int ALLOW_REPEAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  g_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  b_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          step_err,
  output logic [CW-1:0] err_cnt,
  input  logic          clr_err
);

  logic [W-1:0]  w_bin;
  logic          w_accept;
  int unsigned   w_dist;
  logic          w_bad;
  logic [W-1:0]  r_prevG;
  logic          r_havePrev;
  logic          r_stepErr;
  logic [CW-1:0] r_errCnt;

  assign w_bin    = W'(gray2bin(MAX_W'(g_in)));
  assign w_accept = in_valid && in_ready;
  assign w_dist   = popcount(MAX_W'(g_in ^ r_prevG));
  assign w_bad    = w_accept && r_havePrev &&
                    ((w_dist > 1) || ((w_dist == 0) && (ALLOW_REPEAT == 0)));
  assign step_err = r_stepErr;
  assign err_cnt  = r_errCnt;

  gray_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inData  (w_bin),
    .i_inValid (in_valid),
    .o_inReady (in_ready),
    .o_outData (b_out),
    .o_outValid(out_valid),
    .i_outReady(out_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prevG    <= '0;
      r_havePrev <= 1'b0;
    end else if (w_accept) begin
      r_prevG    <= g_in;
      r_havePrev <= 1'b1;
    end
  end

  // A clear discards the old history but still records an error arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stepErr <= 1'b0;
      r_errCnt  <= '0;
    end else if (clr_err) begin
      r_stepErr <= w_bad;
      r_errCnt  <= w_bad ? CW'(1) : '0;
    end else if (w_bad) begin
      r_stepErr <= 1'b1;
      if (r_errCnt != {CW{1'b1}}) begin
        r_errCnt <= r_errCnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_to_bin_stage.sv
// Directed bench for gray_to_bin_stage with W=4, CW=8, ALLOW_REPEAT=1.
module tb_gray_to_bin_stage;
  import gray_pkg::*;

  logic       clk;
  logic       rst_n;
  gray_word_t g_in;
  logic       in_valid;
  logic       in_ready;
  gray_word_t b_out;
  logic       out_valid;
  logic       out_ready;
  logic       step_err;
  logic [7:0] err_cnt;
  logic       clr_err;

  int vecCount;
  int errCount;

  gray_word_t grayTable [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_to_bin_stage #(.W(4), .CW(8), .ALLOW_REPEAT(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .g_in     (g_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .b_out    (b_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .step_err (step_err),
    .err_cnt  (err_cnt),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Present one input word for one clock edge, then settle just after the edge.
  task automatic applyStimulus(input gray_word_t g, input logic valid, input logic clr);
    g_in     = g;
    in_valid = valid;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecCount  = 0;
    errCount  = 0;
    rst_n     = 1'b0;
    g_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_b_out", 32'(b_out), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_step_err", 32'(step_err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic decode");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(grayTable[i], 1'b1, 1'b0);
      checkOutput($sformatf("basic_valid_%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("basic_b_%0d", i), 32'(b_out), 32'(i));
    end
    checkOutput("basic_step_err", 32'(step_err), 32'd0);

    $display("[TB] full cycle with wrap");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(grayTable[i % 16], 1'b1, 1'b0);
      checkOutput($sformatf("full_b_%0d", i), 32'(b_out), 32'(i % 16));
    end
    checkOutput("full_err_cnt", 32'(err_cnt), 32'd0);
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("full_drained", 32'(out_valid), 32'd0);

    $display("[TB] step errors and clear");
    applyStimulus(4'h1, 1'b1, 1'b0);
    checkOutput("step_ok_err", 32'(step_err), 32'd0);
    applyStimulus(4'h2, 1'b1, 1'b0);
    checkOutput("step_bad_err", 32'(step_err), 32'd1);
    checkOutput("step_bad_cnt", 32'(err_cnt), 32'd1);
    applyStimulus(4'h5, 1'b1, 1'b1);
    checkOutput("clr_bad_err", 32'(step_err), 32'd1);
    checkOutput("clr_bad_cnt", 32'(err_cnt), 32'd1);
    checkOutput("clr_bad_b", 32'(b_out), 32'd6);
    applyStimulus(4'h0, 1'b0, 1'b1);
    checkOutput("clr_only_err", 32'(step_err), 32'd0);
    checkOutput("clr_only_cnt", 32'(err_cnt), 32'd0);

    $display("[TB] backpressure");
    applyStimulus(4'h4, 1'b1, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b0);
    out_ready = 1'b0;
    applyStimulus(4'h0, 1'b1, 1'b0);
    checkOutput("bp_ready_1", 32'(in_ready), 32'd1);
    applyStimulus(4'h1, 1'b1, 1'b0);
    checkOutput("bp_ready_2", 32'(in_ready), 32'd0);
    applyStimulus(4'h3, 1'b1, 1'b0);
    checkOutput("bp_ready_3", 32'(in_ready), 32'd0);
    checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_b", 32'(b_out), 32'd0);
    out_ready = 1'b1;
    applyStimulus(4'h3, 1'b1, 1'b0);
    checkOutput("bp_skid_b", 32'(b_out), 32'd1);
    checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
    applyStimulus(4'h3, 1'b1, 1'b0);
    checkOutput("bp_last_b", 32'(b_out), 32'd2);
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("bp_drained", 32'(out_valid), 32'd0);
    checkOutput("bp_err_cnt", 32'(err_cnt), 32'd0);

    $display("[TB] saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus((i % 2 == 0) ? 4'h0 : 4'h3, 1'b1, 1'b0);
      if (i == 9) checkOutput("sat_cnt_10", 32'(err_cnt), 32'd10);
    end
    checkOutput("sat_cnt", 32'(err_cnt), 32'd255);
    checkOutput("sat_err", 32'(step_err), 32'd1);

    $display("[TB] mid-run reset");
    applyStimulus(4'h0, 1'b1, 1'b1);
    out_ready = 1'b0;
    applyStimulus(4'h0, 1'b1, 1'b0);
    applyStimulus(4'h1, 1'b1, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b0);
    checkOutput("mr_full_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mr_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(4'hF, 1'b1, 1'b0);
    checkOutput("mr_first_b", 32'(b_out), 32'd10);
    checkOutput("mr_first_err", 32'(step_err), 32'd0);
    applyStimulus(4'hE, 1'b1, 1'b0);
    checkOutput("mr_next_b", 32'(b_out), 32'd11);
    checkOutput("mr_next_cnt", 32'(err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
